// File: rtl/md_unit_if.sv
// Operand/result bundle for md_unit; optional in_flush exists when MD_UNIT_FLUSH_EN is defined.
// No logic, no latency: wires only.
// Backpressure: valid/ready on the operand side (in_*) and on the result side (out_*).
interface md_unit_if #(
  parameter int WIDTH = 32
);
  logic [WIDTH-1:0] in_src0;
  logic [WIDTH-1:0] in_src1;
  logic [1:0]       in_op;
  logic             in_sign;
`ifdef MD_UNIT_FLUSH_EN
  logic             in_flush;
`endif
  logic             in_valid;
  logic             in_ready;
  logic             out_ready;
  logic             out_valid;
  logic [WIDTH-1:0] out_res0;
  logic [WIDTH-1:0] out_res1;

  // Producer/consumer side, drives operands and takes results.
  modport master (
    output in_src0, in_src1, in_op, in_sign,
`ifdef MD_UNIT_FLUSH_EN
    output in_flush,
`endif
    output in_valid, out_ready,
    input  in_ready, out_valid, out_res0, out_res1
  );

  // Unit side.
  modport slave (
    input  in_src0, in_src1, in_op, in_sign,
`ifdef MD_UNIT_FLUSH_EN
    input  in_flush,
`endif
    input  in_valid, out_ready,
    output in_ready, out_valid, out_res0, out_res1
  );
endinterface

// File: rtl/md_unit.sv
// Multiply/divide unit: full 2*WIDTH product or restoring divide into res1:res0 (MD_UNIT_FLUSH_EN adds in_flush cancel).
// Latency: MUL_CYCLES edges for MUL, WIDTH+1 edges for DIV, from the input handshake to out_valid.
// Backpressure: one op in flight; in_ready only in IDLE; result held in DONE until out_ready.
module md_unit #(
  parameter int WIDTH      = 32,
  parameter int MUL_CYCLES = 1
) (
  input logic    clk,
  input logic    reset,
  md_unit_if.slave bus
);

  localparam int CNT_MAX = (WIDTH > MUL_CYCLES) ? WIDTH : MUL_CYCLES;
  localparam int CNT_W   = $clog2(CNT_MAX + 1);

  localparam logic [1:0] OP_MUL = 2'b01;
  localparam logic [1:0] OP_DIV = 2'b10;

  typedef enum logic [1:0] {
    IDLE     = 2'd0,
    MUL_BUSY = 2'd1,
    DIV_BUSY = 2'd2,
    DONE     = 2'd3
  } state_t;

  state_t             state;
  logic [CNT_W-1:0]   cnt;
  logic [WIDTH-1:0]   op_a;      // MUL multiplicand, or raw dividend for the divide-by-zero remainder
  logic [WIDTH-1:0]   op_b;      // MUL multiplier, or divisor magnitude
  logic               op_sign;
  logic               neg_q;
  logic               neg_r;
  logic               div_zero;
  logic [WIDTH-1:0]   rem;
  logic [WIDTH-1:0]   quo;       // starts as dividend magnitude, shifts out as quotient bits shift in
  logic [WIDTH-1:0]   res0;
  logic [WIDTH-1:0]   res1;

  logic               flush;
  logic [WIDTH-1:0]   mag_src0;
  logic [WIDTH-1:0]   mag_src1;
  logic [2*WIDTH-1:0] a_ext;
  logic [2*WIDTH-1:0] b_ext;
  logic [2*WIDTH-1:0] product;
  logic [WIDTH:0]     rem_sh;
  logic               take;
  logic [WIDTH-1:0]   rem_nxt;

`ifdef MD_UNIT_FLUSH_EN
  assign flush = bus.in_flush;
`else
  assign flush = 1'b0;
`endif

  assign bus.in_ready  = (state == IDLE) & reset & ~flush;
  assign bus.out_valid = (state == DONE);
  assign bus.out_res0  = res0;
  assign bus.out_res1  = res1;

  // Operand magnitudes, product, and one restoring-divide step.
  always_comb begin
    mag_src0 = (bus.in_sign & bus.in_src0[WIDTH-1]) ? (~bus.in_src0 + 1'b1) : bus.in_src0;
    mag_src1 = (bus.in_sign & bus.in_src1[WIDTH-1]) ? (~bus.in_src1 + 1'b1) : bus.in_src1;
    a_ext    = {{WIDTH{op_sign & op_a[WIDTH-1]}}, op_a};
    b_ext    = {{WIDTH{op_sign & op_b[WIDTH-1]}}, op_b};
    // Low 2*WIDTH bits of the sign-extended product equal the signed product.
    product  = a_ext * b_ext;
    rem_sh   = {rem, quo[WIDTH-1]};
    take     = (rem_sh >= {1'b0, op_b});
    rem_nxt  = take ? WIDTH'(rem_sh - {1'b0, op_b}) : rem_sh[WIDTH-1:0];
  end

  // Control FSM and datapath registers.
  always_ff @(posedge clk) begin
    if (!reset) begin
      state    <= IDLE;
      cnt      <= '0;
      op_a     <= '0;
      op_b     <= '0;
      op_sign  <= 1'b0;
      neg_q    <= 1'b0;
      neg_r    <= 1'b0;
      div_zero <= 1'b0;
      rem      <= '0;
      quo      <= '0;
      res0     <= '0;
      res1     <= '0;
    end else if (flush && state != IDLE) begin
      state <= IDLE;
      cnt   <= '0;
      res0  <= '0;
      res1  <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (bus.in_valid && bus.in_ready) begin
            // Reserved/idle op codes are accepted and silently dropped.
            if (bus.in_op == OP_MUL) begin
              state   <= MUL_BUSY;
              cnt     <= CNT_W'(MUL_CYCLES - 1);
              op_a    <= bus.in_src0;
              op_b    <= bus.in_src1;
              op_sign <= bus.in_sign;
            end else if (bus.in_op == OP_DIV) begin
              state    <= DIV_BUSY;
              cnt      <= CNT_W'(WIDTH);
              op_a     <= bus.in_src0;
              op_b     <= mag_src1;
              op_sign  <= bus.in_sign;
              quo      <= mag_src0;
              rem      <= '0;
              neg_q    <= bus.in_sign & (bus.in_src0[WIDTH-1] ^ bus.in_src1[WIDTH-1]);
              neg_r    <= bus.in_sign & bus.in_src0[WIDTH-1];
              div_zero <= (bus.in_src1 == '0);
            end
          end
        end
        MUL_BUSY: begin
          if (cnt == '0) begin
            res1  <= product[2*WIDTH-1:WIDTH];
            res0  <= product[WIDTH-1:0];
            state <= DONE;
          end else begin
            cnt <= cnt - 1'b1;
          end
        end
        DIV_BUSY: begin
          if (cnt != '0) begin
            rem <= rem_nxt;
            quo <= {quo[WIDTH-2:0], take};
            cnt <= cnt - 1'b1;
          end else begin
            // Sign-fix cycle; divide-by-zero overrides the iterated result.
            if (div_zero) begin
              res0 <= '1;
              res1 <= op_a;
            end else begin
              res0 <= neg_q ? (~quo + 1'b1) : quo;
              res1 <= neg_r ? (~rem + 1'b1) : rem;
            end
            state <= DONE;
          end
        end
        DONE: begin
          if (bus.out_ready) begin
            state <= IDLE;
            res0  <= '0;
            res1  <= '0;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_md_unit.sv
// Bench for md_unit: two instances (MUL_CYCLES=1 and 3), directed table plus randomized ops against a model.
// Latency: checks MUL at MUL_CYCLES and DIV at WIDTH+1 edges after the input handshake.
// Backpressure: exercises out_ready stalls, reset abandon, idle op drop and (if enabled) flush.
module tb_md_unit;

  localparam int W       = 32;
  localparam int MC_B    = 3;
  localparam int DIV_LAT = W + 1;
  localparam logic [1:0] OP_MUL = 2'b01;
  localparam logic [1:0] OP_DIV = 2'b10;

  logic clk = 1'b0;
  always #5 clk = ~clk;
  logic rst_n;

  logic [W-1:0] d_src0 [2];
  logic [W-1:0] d_src1 [2];
  logic [1:0]   d_op   [2];
  logic         d_sign [2];
  logic         d_valid[2];
  logic         d_ordy [2];
`ifdef MD_UNIT_FLUSH_EN
  logic         d_flush[2];
`endif
  logic [1:0]   o_irdy;
  logic [1:0]   o_ovld;
  logic [W-1:0] o_r0 [2];
  logic [W-1:0] o_r1 [2];

  md_unit_if #(.WIDTH(W)) if_a ();
  md_unit_if #(.WIDTH(W)) if_b ();

  md_unit #(.WIDTH(W), .MUL_CYCLES(1))    u_dut_a (.clk(clk), .reset(rst_n), .bus(if_a.slave));
  md_unit #(.WIDTH(W), .MUL_CYCLES(MC_B)) u_dut_b (.clk(clk), .reset(rst_n), .bus(if_b.slave));

  assign if_a.in_src0 = d_src0[0];  assign if_b.in_src0 = d_src0[1];
  assign if_a.in_src1 = d_src1[0];  assign if_b.in_src1 = d_src1[1];
  assign if_a.in_op   = d_op[0];    assign if_b.in_op   = d_op[1];
  assign if_a.in_sign = d_sign[0];  assign if_b.in_sign = d_sign[1];
  assign if_a.in_valid  = d_valid[0]; assign if_b.in_valid  = d_valid[1];
  assign if_a.out_ready = d_ordy[0];  assign if_b.out_ready = d_ordy[1];
`ifdef MD_UNIT_FLUSH_EN
  assign if_a.in_flush = d_flush[0]; assign if_b.in_flush = d_flush[1];
`endif
  assign o_irdy = {if_b.in_ready, if_a.in_ready};
  assign o_ovld = {if_b.out_valid, if_a.out_valid};
  assign o_r0[0] = if_a.out_res0;   assign o_r0[1] = if_b.out_res0;
  assign o_r1[0] = if_a.out_res1;   assign o_r1[1] = if_b.out_res1;

  int n_pass  = 0;
  int n_total = 0;

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %h expected %h", nm, act, exp);
  endtask

  // Reference model: plain integer arithmetic.
  function automatic logic [63:0] ref_mul(input logic [W-1:0] a, input logic [W-1:0] b, input logic sg);
    longint          sa, sb;
    longint unsigned ua, ub;
    sa = $signed(a);
    sb = $signed(b);
    ua = {32'd0, a};
    ub = {32'd0, b};
    if (sg) return 64'(sa * sb);
    return ua * ub;
  endfunction

  // Returns {remainder, quotient}.
  function automatic logic [63:0] ref_div(input logic [W-1:0] a, input logic [W-1:0] b, input logic sg);
    int sa, sb;
    sa = a;
    sb = b;
    if (b == 0) return {a, 32'hFFFF_FFFF};
    if (sg) begin
      if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) return {32'h0, 32'h8000_0000};
      return {32'(sa % sb), 32'(sa / sb)};
    end
    return {a % b, a / b};
  endfunction

  // Present an op and return at the negedge after the handshake edge; inputs are then scrambled.
  task automatic start_op(input int s, input logic [1:0] op, input logic sg,
                          input logic [W-1:0] a, input logic [W-1:0] b, input logic ordy,
                          output bit ok);
    int n;
    @(negedge clk);
    d_src0[s] = a; d_src1[s] = b; d_op[s] = op; d_sign[s] = sg;
    d_ordy[s] = ordy; d_valid[s] = 1'b1;
    n = 0;
    while (!o_irdy[s] && n < 100) begin
      @(negedge clk);
      n++;
    end
    ok = o_irdy[s];
    if (!ok) begin
      chk("accept_timeout", 64'(o_irdy[s]), 64'd1);
      d_valid[s] = 1'b0;
      return;
    end
    @(posedge clk);
    @(negedge clk);
    d_valid[s] = 1'b0;
    d_src0[s]  = $urandom;
    d_src1[s]  = $urandom;
    d_sign[s]  = ~sg;
    d_op[s]    = 2'($urandom);
  endtask

  task automatic run_op(input string nm, input int s, input logic [1:0] op, input logic sg,
                        input logic [W-1:0] a, input logic [W-1:0] b,
                        input logic [W-1:0] e0, input logic [W-1:0] e1,
                        input int lat, input int stall);
    int n;
    bit ok, busy_rdy, stable;
    start_op(s, op, sg, a, b, (stall == 0), ok);
    if (!ok) return;
    n = 0;
    busy_rdy = 1'b0;
    while (!o_ovld[s] && n < 200) begin
      if (o_irdy[s]) busy_rdy = 1'b1;
      @(negedge clk);
      n++;
    end
    if (o_irdy[s]) busy_rdy = 1'b1;
    chk({nm, "_latency"}, 64'(n), 64'(lat));
    chk({nm, "_busy_in_ready"}, 64'(busy_rdy), 64'd0);
    chk({nm, "_res0"}, 64'(o_r0[s]), 64'(e0));
    chk({nm, "_res1"}, 64'(o_r1[s]), 64'(e1));
    if (stall > 0) begin
      stable = 1'b1;
      for (int i = 0; i < stall; i++) begin
        @(negedge clk);
        if (!o_ovld[s] || o_r0[s] != e0 || o_r1[s] != e1) stable = 1'b0;
      end
      chk({nm, "_stall_stable"}, 64'(stable), 64'd1);
      d_ordy[s] = 1'b1;
    end
    @(negedge clk);
    chk({nm, "_retire"}, {31'd0, o_ovld[s], o_r1[s] | o_r0[s]}, 64'd0);
    chk({nm, "_ready_after"}, 64'(o_irdy[s]), 64'd1);
  endtask

  task automatic watch_quiet(input string nm, input int s, input int cycles);
    bit seen;
    seen = 1'b0;
    for (int i = 0; i < cycles; i++) begin
      @(negedge clk);
      if (o_ovld[s]) seen = 1'b1;
    end
    chk({nm, "_no_result"}, 64'(seen), 64'd0);
  endtask

  typedef struct {
    int         s;
    logic [1:0] op;
    logic       sg;
    logic [W-1:0] a, b, e0, e1;
    int         lat;
    int         stall;
  } vec_t;

  vec_t vecs[11];

  initial begin
    #600000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    bit ok;
    logic [63:0] exp;
    vecs[0]  = '{0, OP_MUL, 1'b1, 32'hFFFF_FFFD, 32'd7,        32'hFFFF_FFEB, 32'hFFFF_FFFF, 1,       0};
    vecs[1]  = '{1, OP_MUL, 1'b0, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'h0000_0001, 32'hFFFF_FFFE, MC_B,    5};
    vecs[2]  = '{0, OP_DIV, 1'b1, 32'hFFFF_FFF9, 32'd2,        32'hFFFF_FFFD, 32'hFFFF_FFFF, DIV_LAT, 0};
    vecs[3]  = '{0, OP_DIV, 1'b0, 32'd100,       32'd0,        32'hFFFF_FFFF, 32'd100,       DIV_LAT, 0};
    vecs[4]  = '{1, OP_DIV, 1'b1, 32'h8000_0000, 32'hFFFF_FFFF, 32'h8000_0000, 32'h0,        DIV_LAT, 0};
    vecs[5]  = '{0, OP_DIV, 1'b1, 32'hFFFF_FFFB, 32'd0,        32'hFFFF_FFFF, 32'hFFFF_FFFB, DIV_LAT, 1};
    vecs[6]  = '{1, OP_MUL, 1'b1, 32'h8000_0000, 32'h8000_0000, 32'h0,        32'h4000_0000, MC_B,    1};
    vecs[7]  = '{0, OP_MUL, 1'b0, 32'hFFFF_FFFF, 32'd2,        32'hFFFF_FFFE, 32'h1,         1,       2};
    vecs[8]  = '{1, OP_DIV, 1'b1, 32'd7,         32'hFFFF_FFFE, 32'hFFFF_FFFD, 32'd1,        DIV_LAT, 0};
    vecs[9]  = '{0, OP_DIV, 1'b0, 32'hFFFF_FFFF, 32'd10,       32'h1999_9999, 32'd5,         DIV_LAT, 0};
    vecs[10] = '{0, OP_MUL, 1'b1, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'h1,        32'h0,         1,       0};

    rst_n = 1'b0;
    for (int s = 0; s < 2; s++) begin
      d_src0[s] = '0; d_src1[s] = '0; d_op[s] = '0; d_sign[s] = 1'b0;
      d_valid[s] = 1'b0; d_ordy[s] = 1'b0;
`ifdef MD_UNIT_FLUSH_EN
      d_flush[s] = 1'b0;
`endif
    end
    repeat (3) @(negedge clk);
    for (int s = 0; s < 2; s++) begin
      chk("reset_in_ready", 64'(o_irdy[s]), 64'd0);
      chk("reset_out", {31'd0, o_ovld[s], o_r1[s] | o_r0[s]}, 64'd0);
    end
    rst_n = 1'b1;
    #1;
    chk("release_in_ready", 64'(o_irdy), 64'd3);

    // Directed vectors.
    for (int i = 0; i < 11; i++)
      run_op($sformatf("vec%0d", i), vecs[i].s, vecs[i].op, vecs[i].sg, vecs[i].a, vecs[i].b,
             vecs[i].e0, vecs[i].e1, vecs[i].lat, vecs[i].stall);

    // Idle / reserved op codes are consumed without a result.
    start_op(0, 2'b00, 1'b0, 32'd5, 32'd6, 1'b1, ok);
    chk("op00_ready", 64'(o_irdy[0]), 64'd1);
    watch_quiet("op00", 0, 40);
    start_op(0, 2'b11, 1'b1, 32'd5, 32'd6, 1'b1, ok);
    chk("op11_ready", 64'(o_irdy[0]), 64'd1);
    watch_quiet("op11", 0, 40);

    // Reset at busy cycle 10 of a divide abandons it.
    start_op(0, OP_DIV, 1'b0, 32'd100, 32'd7, 1'b1, ok);
    repeat (9) @(negedge clk);
    rst_n = 1'b0;
    @(negedge clk);
    chk("rst_mid_out", {31'd0, o_ovld[0], o_r1[0] | o_r0[0]}, 64'd0);
    chk("rst_mid_in_ready", 64'(o_irdy[0]), 64'd0);
    @(negedge clk);
    rst_n = 1'b1;
    #1;
    chk("rst_mid_release", 64'(o_irdy[0]), 64'd1);
    watch_quiet("rst_mid", 0, 50);

`ifdef MD_UNIT_FLUSH_EN
    // Flush a multiply at busy cycle 2, then run a divide.
    start_op(1, OP_MUL, 1'b0, 32'd11, 32'd13, 1'b1, ok);
    @(negedge clk);
    d_flush[1] = 1'b1;
    @(negedge clk);
    chk("flush_out", {31'd0, o_ovld[1], o_r1[1] | o_r0[1]}, 64'd0);
    chk("flush_blocks_ready", 64'(o_irdy[1]), 64'd0);
    d_flush[1] = 1'b0;
    #1;
    chk("flush_ready_after", 64'(o_irdy[1]), 64'd1);
    watch_quiet("flush", 1, 10);
    run_op("flush_div", 1, OP_DIV, 1'b0, 32'd9, 32'd3, 32'd3, 32'd0, DIV_LAT, 0);
`endif

    // Randomized ops against the model.
    for (int i = 0; i < 60; i++) begin
      int s, sel, lat;
      logic [1:0] op;
      logic sg;
      logic [W-1:0] a, b;
      s   = $urandom_range(0, 1);
      op  = ($urandom_range(0, 1) == 0) ? OP_MUL : OP_DIV;
      sg  = 1'($urandom);
      a   = $urandom;
      b   = $urandom;
      sel = $urandom_range(0, 7);
      if (sel == 0) b = '0;
      else if (sel == 1) begin a = 32'h8000_0000; b = 32'hFFFF_FFFF; end
      else if (sel == 2) b = 32'($urandom_range(1, 20));
      else if (sel == 3) a = 32'h8000_0000;
      if (op == OP_MUL) begin
        exp = ref_mul(a, b, sg);
        lat = (s == 1) ? MC_B : 1;
      end else begin
        exp = ref_div(a, b, sg);
        lat = DIV_LAT;
      end
      run_op($sformatf("rnd%0d", i), s, op, sg, a, b, exp[31:0], exp[63:32], lat,
             $urandom_range(0, 2));
    end

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
